// File: rtl/mealy_trace_decoder.sv
// mealy_trace_decoder
// Monitor-side inverse of the 6-state Mealy sequencer. It watches the sampled
// state stream, recovers the serial input bit that caused each transition,
// packs the recovered bits into bytes and flags illegal samples. If a sample
// cannot be explained, the decoder drops to HUNT and re-locks on the next
// legal state value.
module mealy_trace_decoder #(
    parameter bit MSB_FIRST = 1'b1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           state_in,
    input  logic                 state_valid,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic [7:0]           byte_out,
    output logic                 byte_valid,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 synced
);

    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,
        ST_HUNT  = 1'b1
    } dec_state_e;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // Sequencer successor of s when the serial input is 0.
    function automatic logic [2:0] next0(input logic [2:0] s);
        case (s)
            3'd0:    next0 = 3'd1;
            3'd1:    next0 = 3'd2;
            3'd2:    next0 = 3'd3;
            3'd3:    next0 = 3'd4;
            3'd4:    next0 = 3'd5;
            3'd5:    next0 = 3'd0;
            default: next0 = 3'd0;
        endcase
    endfunction

    // Sequencer successor of s when the serial input is 1.
    function automatic logic [2:0] next1(input logic [2:0] s);
        case (s)
            3'd0:    next1 = 3'd3;
            3'd1:    next1 = 3'd5;
            3'd2:    next1 = 3'd0;
            3'd3:    next1 = 3'd1;
            3'd4:    next1 = 3'd2;
            3'd5:    next1 = 3'd4;
            default: next1 = 3'd0;
        endcase
    endfunction

    dec_state_e             state_q,      state_d;
    logic [2:0]             prev_q,       prev_d;
    logic [7:0]             shift_q,      shift_d;
    logic [2:0]             cnt_q,        cnt_d;
    logic                   bit_out_q,    bit_out_d;
    logic                   bit_valid_q,  bit_valid_d;
    logic [7:0]             byte_out_q,   byte_out_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   err_q,        err_d;
    logic [ERR_CNT_W-1:0]   err_count_q,  err_count_d;
    logic                   synced_q,     synced_d;

    logic                   legal_s;
    logic                   emit_s;
    logic                   rec_bit_s;
    logic [7:0]             shift_next_s;

    // Sample is a legal sequencer state code (0..5).
    always_comb begin
        legal_s = (state_in <= 4'd5);
    end

    // Shift register contents after appending the recovered bit.
    always_comb begin
        shift_next_s = 8'h00;
        if (MSB_FIRST) begin
            shift_next_s = {shift_q[6:0], rec_bit_s};
        end else begin
            shift_next_s = {rec_bit_s, shift_q[7:1]};
        end
    end

    // Next-state and output decode: classify the sample, recover the bit,
    // pack bytes and raise errors.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        emit_s       = 1'b0;
        rec_bit_s    = 1'b0;

        if (state_valid) begin
            case (state_q)
                ST_TRACK: begin
                    if (!legal_s) begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                        cnt_d   = 3'd0;
                        shift_d = 8'h00;
                    end else if (state_in[2:0] == next0(prev_q)) begin
                        emit_s    = 1'b1;
                        rec_bit_s = 1'b0;
                    end else if (state_in[2:0] == next1(prev_q)) begin
                        emit_s    = 1'b1;
                        rec_bit_s = 1'b1;
                    end else begin
                        // Unreachable successor (includes a repeated state):
                        // the partial byte cannot be trusted any more.
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                        cnt_d   = 3'd0;
                        shift_d = 8'h00;
                    end
                end
                ST_HUNT: begin
                    if (legal_s) begin
                        prev_d  = state_in[2:0];
                        state_d = ST_TRACK;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    cnt_d   = 3'd0;
                    shift_d = 8'h00;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (emit_s) begin
            prev_d      = state_in[2:0];
            bit_out_d   = rec_bit_s;
            bit_valid_d = 1'b1;
            shift_d     = shift_next_s;
            if (cnt_q == 3'd7) begin
                byte_out_d   = shift_next_s;
                byte_valid_d = 1'b1;
                cnt_d        = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end else begin
            bit_out_d = bit_out_q;
        end

        if (err_d && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_ONE;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // synced tracks the state the FSM is about to enter so it is registered.
    always_comb begin
        synced_d = (state_d == ST_TRACK);
    end

    // State and output registers; reset assumes the sequencer sits in state 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_TRACK;
            prev_q       <= 3'd0;
            shift_q      <= 8'h00;
            cnt_q        <= 3'd0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= {ERR_CNT_W{1'b0}};
            synced_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            synced_q     <= synced_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign synced     = synced_q;

endmodule

// File: tb/tb_mealy_trace_decoder.sv
// Self-checking bench for mealy_trace_decoder: a reference model built from
// the sequencer transition table pushes the expected outputs of every cycle
// into a scoreboard queue, which is popped and compared after each edge.
module tb_mealy_trace_decoder;

    localparam bit TB_MSB = 1'b1;

    logic       clk;
    logic       reset;
    logic [3:0] state_in;
    logic       state_valid;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       err;
    logic [7:0] err_count;
    logic       synced;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       bv;
        logic       b;
        logic       byv;
        logic [7:0] by;
        logic       e;
        logic [7:0] ec;
        logic       sy;
    } exp_t;

    exp_t sb_q[$];

    // reference model state
    int         n0 [6] = '{1, 2, 3, 4, 5, 0};
    int         n1 [6] = '{3, 5, 0, 1, 2, 4};
    logic       m_track;
    int         m_prev;
    logic [7:0] m_shift;
    int         m_cnt;
    logic       m_bit;
    logic [7:0] m_byte;
    int         m_ec;

    mealy_trace_decoder #(.MSB_FIRST(TB_MSB), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .state_in   (state_in),
        .state_valid(state_valid),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .err        (err),
        .err_count  (err_count),
        .synced     (synced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_track = 1'b1;
        m_prev  = 0;
        m_shift = 8'h00;
        m_cnt   = 0;
        m_bit   = 1'b0;
        m_byte  = 8'h00;
        m_ec    = 0;
    endtask

    // Advance the model by one sample and push the expected outputs.
    task automatic model_step(input logic v, input logic [3:0] c);
        exp_t x;
        int   ci;
        logic emit;
        logic b;
        ci     = int'(c);
        emit   = 1'b0;
        b      = 1'b0;
        x.bv   = 1'b0;
        x.byv  = 1'b0;
        x.e    = 1'b0;
        if (v) begin
            if (m_track) begin
                if (ci <= 5 && ci == n0[m_prev]) begin
                    emit = 1'b1; b = 1'b0;
                end else if (ci <= 5 && ci == n1[m_prev]) begin
                    emit = 1'b1; b = 1'b1;
                end else begin
                    x.e = 1'b1; m_track = 1'b0; m_cnt = 0; m_shift = 8'h00;
                end
            end else begin
                if (ci <= 5) begin
                    m_prev = ci; m_track = 1'b1;
                end else begin
                    x.e = 1'b1;
                end
            end
        end
        if (emit) begin
            m_prev = ci;
            m_bit  = b;
            x.bv   = 1'b1;
            if (TB_MSB) m_shift = {m_shift[6:0], b};
            else        m_shift = {b, m_shift[7:1]};
            m_cnt++;
            if (m_cnt == 8) begin
                m_cnt  = 0;
                m_byte = m_shift;
                x.byv  = 1'b1;
            end
        end
        if (x.e && m_ec < 255) m_ec++;
        x.b  = m_bit;
        x.by = m_byte;
        x.ec = 8'(m_ec);
        x.sy = m_track;
        sb_q.push_back(x);
    endtask

    task automatic compare(input string tag);
        exp_t x;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            x = sb_q.pop_front();
            chk({tag, ".bit_valid"},  32'(bit_valid),  32'(x.bv));
            chk({tag, ".bit_out"},    32'(bit_out),    32'(x.b));
            chk({tag, ".byte_valid"}, 32'(byte_valid), 32'(x.byv));
            chk({tag, ".byte_out"},   32'(byte_out),   32'(x.by));
            chk({tag, ".err"},        32'(err),        32'(x.e));
            chk({tag, ".err_count"},  32'(err_count),  32'(x.ec));
            chk({tag, ".synced"},     32'(synced),     32'(x.sy));
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [3:0] c);
        @(negedge clk);
        state_valid = v;
        state_in    = c;
        model_step(v, c);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        state_valid = 1'b0;
        state_in    = 4'd0;
        reset       = 1'b0;
        model_reset();
        #1;
        model_step(1'b0, 4'd0);
        compare({tag, ".in_reset"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        state_valid = 1'b0;
        state_in    = 4'd0;
        model_reset();
        #2;

        // Test 1: reset, then 1,2,3 -> bits 0,0,0
        do_reset("t1");
        step("t1.s1", 1'b1, 4'd1);
        step("t1.s2", 1'b1, 4'd2);
        step("t1.s3", 1'b1, 4'd3);
        step("t1.idle", 1'b0, 4'd0);

        // Test 2: 3,4,2,0,1,2,0,1 -> byte 0xB2
        do_reset("t2");
        step("t2.s1", 1'b1, 4'd3);
        step("t2.s2", 1'b1, 4'd4);
        step("t2.s3", 1'b1, 4'd2);
        step("t2.s4", 1'b1, 4'd0);
        step("t2.s5", 1'b1, 4'd1);
        step("t2.s6", 1'b1, 4'd2);
        step("t2.s7", 1'b1, 4'd0);
        step("t2.s8", 1'b1, 4'd1);
        chk("t2.byte_const", 32'(byte_out), TB_MSB ? 32'h0000_00B2 : 32'h0000_004D);
        chk("t2.byte_pulse", 32'(byte_valid), 32'h0000_0001);
        step("t2.idle", 1'b0, 4'd0);

        // Test 3: illegal successor, hunt re-lock, then out-of-range sample
        do_reset("t3");
        step("t3.err", 1'b1, 4'd2);
        chk("t3.synced_lost", 32'(synced), 32'h0000_0000);
        step("t3.relock", 1'b1, 4'd5);
        chk("t3.synced_back", 32'(synced), 32'h0000_0001);
        step("t3.bit1", 1'b1, 4'd4);
        step("t3.bad7", 1'b1, 4'd7);
        chk("t3.count2", 32'(err_count), 32'h0000_0002);
        step("t3.hunt7", 1'b1, 4'd9);
        step("t3.idle", 1'b0, 4'd0);

        // Test 4: partial byte with idles, reset mid-byte, then all-zero byte
        do_reset("t4");
        step("t4.s1", 1'b1, 4'd3);
        step("t4.i1", 1'b0, 4'd5);
        step("t4.s2", 1'b1, 4'd4);
        step("t4.i2", 1'b0, 4'd0);
        step("t4.i3", 1'b0, 4'd1);
        step("t4.s3", 1'b1, 4'd2);
        do_reset("t4.mid");
        step("t4.z1", 1'b1, 4'd1);
        step("t4.z2", 1'b1, 4'd2);
        step("t4.z3", 1'b1, 4'd3);
        step("t4.z4", 1'b1, 4'd4);
        step("t4.z5", 1'b1, 4'd5);
        step("t4.z6", 1'b1, 4'd0);
        step("t4.z7", 1'b1, 4'd1);
        step("t4.z8", 1'b1, 4'd2);
        chk("t4.byte_zero", 32'(byte_out), 32'h0000_0000);
        chk("t4.byte_pulse", 32'(byte_valid), 32'h0000_0001);

        // Test 5: repeated state, then counter saturation
        do_reset("t5");
        step("t5.s1", 1'b1, 4'd3);
        step("t5.rep", 1'b1, 4'd3);
        for (int i = 0; i < 300; i++) begin
            step("t5.sat", 1'b1, 4'(6 + (i % 10)));
        end
        chk("t5.sat_const", 32'(err_count), 32'h0000_00FF);
        step("t5.relock", 1'b1, 4'd0);
        step("t5.after", 1'b1, 4'd3);
        chk("t5.still_sat", 32'(err_count), 32'h0000_00FF);

        chk("sb.drained", 32'(sb_q.size()), 32'h0000_0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mealy_trace_decoder.md
Name: mealy_trace_decoder

Overview:
- Receiver-side inverse of the team's 6-state Mealy sequencer.
- Watches the sequencer's 4-bit state stream and recovers the serial input bit that caused each transition.
- Packs the recovered bits into bytes and flags illegal transitions.
- Used on the monitor/debug side to reconstruct the input sequence from observed state alone.

Parameters:
- MSB_FIRST, 1, 1 = first recovered bit lands in byte_out[7]; 0 = first bit lands in byte_out[0].
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- state_in  input  4  sampled sequencer state; legal values 0..5.
- state_valid  input  1  state_in is a new sample this cycle.
- bit_out  output  1  recovered input bit.
- bit_valid  output  1  one-cycle pulse; bit_out valid.
- byte_out  output  8  assembled byte; held until the next byte completes.
- byte_valid  output  1  one-cycle pulse; byte_out updated.
- err  output  1  one-cycle pulse on an illegal sample.
- err_count  output  ERR_CNT_W  saturating count of err pulses.
- synced  output  1  1 while in TRACK.

Behaviour:
- Reference transition table, state: next if in=0 / next if in=1.
  - 0: 1/3
  - 1: 2/5
  - 2: 3/0
  - 3: 4/1
  - 4: 5/2
  - 5: 0/4
- Reset (async, reset=0):
  - FSM goes to TRACK; prev=0, because the sequencer also resets to 0.
  - Shift register cleared; bit counter=0.
  - bit_out, bit_valid, byte_out, byte_valid, err and err_count all 0; synced=1.
- FSM states: TRACK, HUNT. All outputs are registered.
- Latency: a sample accepted at edge N produces bit_valid, byte_valid or err during cycle N+1. Pulses last exactly one cycle.
- state_valid=0: no state change; all pulses deassert.
- TRACK, state_valid=1, c = state_in:
  - c > 5: err; go to HUNT; partial byte discarded (bit counter=0).
  - c == next0(prev): bit 0 recovered; prev=c.
  - c == next1(prev): bit 1 recovered; prev=c.
  - Any other c, including c == prev: err; go to HUNT; partial byte discarded.
- HUNT, state_valid=1:
  - c <= 5: prev=c; go to TRACK; no bit emitted, no err.
  - c > 5: err; stay in HUNT.
- Bit packing:
  - MSB_FIRST=1: shift = {shift[6:0], bit}.
  - MSB_FIRST=0: shift = {bit, shift[7:1]}.
  - On the 8th bit: byte_out is loaded, byte_valid pulses in the same cycle as that bit_valid, and the counter wraps to 0.
- err_count increments once per err pulse and saturates at 2^ERR_CNT_W - 1; only reset clears it.
- Reset asserted mid-byte: partial byte lost; decoding resumes with prev=0 once reset deasserts.
- next0 and next1 differ for every state, so decoding is never ambiguous.

Test Plan:
- Reset, then samples 1,2,3 with state_valid=1 → bit_out 0,0,0, each 1 cycle after its sample; err=0; synced=1.
- From reset, samples 3,4,2,0,1,2,0,1 → bits 1,0,1,1,0,0,1,0; byte_valid pulses once with byte_out=0xB2 (MSB_FIRST=1), or 0x4D (MSB_FIRST=0).
- From reset, sample 2 → err pulse, err_count=1, synced=0.
  - Then sample 5 → synced=1, no bit.
  - Then sample 4 → bit 1.
  - Then sample 7 → err, err_count=2, HUNT.
- Samples 3,4,2 interleaved with idle cycles (state_valid=0) → bits 1,0,1 with no extra pulses; then reset pulsed low and released, then samples 1,2,3,4,5,0,1,2 → byte_out=0x00; the earlier partial bits do not appear.
- Repeated value 3,3 → err on the second sample; 300 consecutive illegal samples → err_count saturates at 255.
